bus_memory: RTL and testbench
=============================

// Module: bus_memory
// PURPOSE
// - Word-addressed memory responder on the cpu's data bus (address/rw/datao -> data).
// - Services cpu reads (rw=1) and writes (rw=0). Also provides a program-load port.
// - The loader fills memory from address 0 while the cpu is held in reset, then signals done.
// - Flags cpu accesses that fall outside the implemented depth.
// PARAMETERS
// - DEPTH_LOG2 8  : log2 of the number of 64-bit words (256 words).
// - DATA_W     64 : word width; must match the cpu bus.
// PORTS
// - clock      in  1      : single clock; all state updates on posedge clock.
// - reset      in  1      : asynchronous, active-high; clears all registers and outputs.
// - address    in  64     : word address from the cpu.
// - rw         in  1      : 1 = read, 0 = write.
// - datai      in  DATA_W : write data (cpu datao).
// - data       out DATA_W : registered read data to the cpu.
// - fault      out 1      : sticky; set when a cpu access has address >= 2**DEPTH_LOG2.
// - load_mode  in  1      : 1 = loader owns memory and the cpu bus is ignored.
// - load_valid in  1      : loader word present.
// - load_ready out 1      : memory accepts a loader word this cycle.
// - load_data  in  DATA_W : loader word.
// - load_len   in  DEPTH_LOG2+1 : number of words to load (0..2**DEPTH_LOG2).
// - load_done  out 1      : one-cycle pulse when loading ends.
// - load_count out DEPTH_LOG2+1 : number of words accepted so far.
// BEHAVIOUR
// - Reset values: data=0, fault=0, load_ready=0, load_done=0, load_count=0, FSM=IDLE.
// - Memory array contents are not reset.
// - FSM states:
//   - IDLE: serves the cpu bus.
//   - LOAD: loader active.
//   - DONE: lasts one cycle.
// - IDLE -> LOAD when load_mode=1; load_count is cleared on entry.
// - LOAD: load_ready=1. When load_valid&&load_ready:
//   - write mem[load_count] = load_data;
//   - load_count increments.
// - LOAD -> DONE when the accepted word makes load_count==load_len.
// - LOAD -> DONE when load_mode drops (partial load; count is retained).
// - load_len=0: LOAD -> DONE on the first LOAD cycle, with no write.
// - DONE: load_done=1, load_ready=0, then -> IDLE. load_count holds until the next LOAD entry.
// - Cpu read (IDLE, rw=1, in range): data <= mem[address] at the next posedge (latency 1).
// - Cpu write (IDLE, rw=0, in range): mem[address] <= datai at the posedge.
//   - data keeps its previous value.
// - Read-during-write does not apply: the bus carries one op per cycle.
// - Out-of-range access:
//   - no array access; data <= 0; fault <= 1.
//   - fault stays set until reset.
// - In LOAD/DONE the cpu bus is ignored entirely: no writes, data holds, fault unchanged.
// - Index arithmetic uses the low DEPTH_LOG2 bits only after the range check passes.
// - The load_count compare is at full DEPTH_LOG2+1 width, so a full-depth load does not wrap.
// - Reset mid-LOAD: immediate return to IDLE. Words already written remain, and no load_done pulse is produced.
// STRUCTURE
// - Shared package: FSM state encoding (IDLE=0, LOAD=1, DONE=2) and the BUS_READ=1 / BUS_WRITE=0 constants.
// - One sub-module, mem_array: a 2**DEPTH_LOG2 x DATA_W single-port synchronous array.
//   - Ports: clock, we, idx, wdata, rdata.
//   - Registered read.
//   - The muxing between the loader and the cpu is done in bus_memory.
// TESTING
// - Reset released with rw=1, address=0 -> data=0, fault=0, load_ready=0.
// - Load: load_mode=1, load_len=3, words 0x11,0x22,0x33 with valid held high:
//   - load_ready=1 for 3 cycles;
//   - load_done pulses once in the cycle after the third accept;
//   - load_count=3.
// - After load: cpu reads address 1 -> data=0x22 one cycle later.
// - Cpu writes address 5 = 0xDEADBEEF (rw=0), then reads 5 -> 0xDEADBEEF.
//   - During the write cycle data holds its prior value.
// - Cpu read at address 256 (DEPTH_LOG2=8):
//   - data=0, fault=1;
//   - a subsequent in-range read returns the stored word while fault stays 1;
//   - reset clears fault.
// - Partial load, load_len=4: drop load_mode after 2 accepts -> load_done pulse, load_count=2.
// - Second partial load, load_len=4: assert reset after 2 accepts -> FSM=IDLE, no load_done pulse, and the first 2 words are retained.

Source files
------------

// File: rtl/bus_memory_pkg.sv
// bus_memory_pkg
// Shared definitions for the bus_memory slice: the loader FSM state encoding
// and the cpu bus direction constants carried on the rw line.
//
// Contents:
//   load_state_t : IDLE (cpu owns memory), LOAD (loader owns memory),
//                  DONE (single-cycle completion state)
//   BUS_READ     : value of rw for a cpu read
//   BUS_WRITE    : value of rw for a cpu write
//   DEF_DEPTH_LOG2 / DEF_DATA_W : default geometry for the memory

package bus_memory_pkg;

   localparam int DEF_DEPTH_LOG2 = 8;
   localparam int DEF_DATA_W     = 64;

   localparam logic BUS_READ  = 1'b1;
   localparam logic BUS_WRITE = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } load_state_t;

endpackage

// File: rtl/bus_memory_mem_array.sv
// mem_array
// Single-port synchronous memory of 2**DEPTH_LOG2 words of DATA_W bits.
// The read is registered and read-first: rdata shows the word that was at
// idx before any write performed on the same edge. Contents are not reset.
//
// Ports:
//   clock : write and read-register clock
//   we    : write enable for mem[idx]
//   idx   : word index
//   wdata : write data
//   rdata : registered read data (mem[idx] sampled on the last edge)

module mem_array #(
   parameter int DEPTH_LOG2 = 8,
   parameter int DATA_W     = 64
) (
   input  logic                  clock,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] idx,
   input  logic [DATA_W-1:0]     wdata,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

   // Storage and registered read port; no reset so the array maps onto RAM.
   always_ff @(posedge clock) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      rdata <= mem[idx];
   end

endmodule

// File: rtl/bus_memory.sv
// bus_memory
// Word-addressed memory responder for the cpu data bus, with a program-load
// port that fills memory from address 0 while the cpu is held off.
//
// Ports:
//   clock, reset           : clock and asynchronous active-high reset
//   address, rw, datai     : cpu bus (rw=1 read, rw=0 write)
//   data                   : read data to the cpu, one cycle after a read
//   fault                  : sticky out-of-range access flag
//   load_mode              : loader owns memory while high
//   load_valid, load_ready : loader word handshake
//   load_data, load_len    : loader word and number of words to load
//   load_done              : single-cycle pulse at the end of a load
//   load_count             : words accepted by the current/last load

module bus_memory
   import bus_memory_pkg::*;
#(
   parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
   parameter int DATA_W     = DEF_DATA_W
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [63:0]           address,
   input  logic                  rw,
   input  logic [DATA_W-1:0]     datai,
   output logic [DATA_W-1:0]     data,
   output logic                  fault,
   input  logic                  load_mode,
   input  logic                  load_valid,
   output logic                  load_ready,
   input  logic [DATA_W-1:0]     load_data,
   input  logic [DEPTH_LOG2:0]   load_len,
   output logic                  load_done,
   output logic [DEPTH_LOG2:0]   load_count
);

   localparam int CW = DEPTH_LOG2 + 1;

   load_state_t state;
   load_state_t state_next;

   logic                  in_range;
   logic                  cpu_active;
   logic                  load_accept;
   logic [CW-1:0]         count_inc;

   logic                  mem_we;
   logic [DEPTH_LOG2-1:0] mem_idx;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W-1:0]     mem_rdata;

   // The array's registered read already gives one-cycle latency, so the
   // output is a mux between that register and a holding register. sel_mem
   // remembers whether the last cpu cycle was an in-range read; otherwise
   // data_hold keeps the previous value (or zero after an out-of-range access).
   logic                  sel_mem;
   logic [DATA_W-1:0]     data_hold;

   assign in_range    = ~|address[63:DEPTH_LOG2];
   assign cpu_active  = (state == IDLE);
   assign count_inc   = load_count + CW'(1);

   // Ready only while a word can actually be taken: a zero-length load or a
   // dropped load_mode ends the load without another write.
   assign load_ready  = (state == LOAD) && load_mode && (load_count != load_len);
   assign load_accept = load_ready && load_valid;
   assign load_done   = (state == DONE);

   // Port sharing: the cpu drives the array only in IDLE, the loader otherwise.
   always_comb begin
      mem_we    = 1'b0;
      mem_idx   = load_count[DEPTH_LOG2-1:0];
      mem_wdata = load_data;
      if (cpu_active) begin
         mem_we    = in_range && (rw == BUS_WRITE);
         mem_idx   = address[DEPTH_LOG2-1:0];
         mem_wdata = datai;
      end else begin
         mem_we    = load_accept;
      end
   end

   mem_array #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DATA_W     (DATA_W)
   ) u_mem_array (
      .clock (clock),
      .we    (mem_we),
      .idx   (mem_idx),
      .wdata (mem_wdata),
      .rdata (mem_rdata)
   );

   assign data = sel_mem ? mem_rdata : data_hold;

   // Loader FSM state register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Loader FSM next state. The load ends when the accepted word reaches
   // load_len (compared at full width so a full-depth load cannot wrap),
   // when load_len is already met, or when load_mode is withdrawn.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (load_mode) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (!load_mode || (load_count == load_len)) begin
               state_next = DONE;
            end else if (load_accept && (count_inc == load_len)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Word counter: cleared on entry to LOAD, held through DONE and IDLE so
   // the result of the last load stays visible.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         load_count <= '0;
      end else if (cpu_active && load_mode) begin
         load_count <= '0;
      end else if (load_accept) begin
         load_count <= count_inc;
      end
   end

   // Cpu read-data selection and the sticky fault flag. Outside IDLE the
   // bus is ignored, so the visible data is frozen into data_hold.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sel_mem   <= 1'b0;
         data_hold <= '0;
         fault     <= 1'b0;
      end else if (cpu_active) begin
         if (!in_range) begin
            sel_mem   <= 1'b0;
            data_hold <= '0;
            fault     <= 1'b1;
         end else if (rw == BUS_READ) begin
            sel_mem   <= 1'b1;
         end else begin
            sel_mem   <= 1'b0;
            data_hold <= data;
         end
      end else begin
         sel_mem   <= 1'b0;
         data_hold <= data;
      end
   end

endmodule

// File: tb/tb_bus_memory.sv
// tb_bus_memory
// Directed self-checking bench for bus_memory: reset state, program load,
// cpu read/write, out-of-range fault, partial loads, zero-length load and
// reset in the middle of a load.

module tb_bus_memory;

   localparam int DEPTH_LOG2 = 8;
   localparam int DATA_W     = 64;

   logic                clock;
   logic                reset;
   logic [63:0]         address;
   logic                rw;
   logic [DATA_W-1:0]   datai;
   logic [DATA_W-1:0]   data;
   logic                fault;
   logic                load_mode;
   logic                load_valid;
   logic                load_ready;
   logic [DATA_W-1:0]   load_data;
   logic [DEPTH_LOG2:0] load_len;
   logic                load_done;
   logic [DEPTH_LOG2:0] load_count;

   int assert_count;
   int fail_count;

   bus_memory #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DATA_W     (DATA_W)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .address    (address),
      .rw         (rw),
      .datai      (datai),
      .data       (data),
      .fault      (fault),
      .load_mode  (load_mode),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_data  (load_data),
      .load_len   (load_len),
      .load_done  (load_done),
      .load_count (load_count)
   );

   // Free-running 10-unit clock.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", tag, actual, expected);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present one cpu bus operation and let it take effect.
   task automatic applyStimulus(input logic rw_v, input logic [63:0] addr_v, input logic [63:0] wdata_v);
      rw      = rw_v;
      address = addr_v;
      datai   = wdata_v;
      tick();
   endtask

   initial begin
      logic [63:0] words [3];
      words[0] = 64'h11;
      words[1] = 64'h22;
      words[2] = 64'h33;

      assert_count = 0;
      fail_count   = 0;
      reset        = 1'b1;
      address      = 64'd0;
      rw           = 1'b1;
      datai        = '0;
      load_mode    = 1'b0;
      load_valid   = 1'b0;
      load_data    = '0;
      load_len     = '0;

      // Reset state
      tick();
      tick();
      reset = 1'b0;
      checkOutput("reset_data", data, 64'd0);
      checkOutput("reset_fault", {63'd0, fault}, 64'd0);
      checkOutput("reset_ready", {63'd0, load_ready}, 64'd0);
      checkOutput("reset_done", {63'd0, load_done}, 64'd0);
      checkOutput("reset_count", {55'd0, load_count}, 64'd0);

      // Full load of three words with valid held high
      load_mode  = 1'b1;
      load_len   = 9'd3;
      load_valid = 1'b1;
      load_data  = words[0];
      tick();
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("load_ready_%0d", i), {63'd0, load_ready}, 64'd1);
         checkOutput($sformatf("load_done_low_%0d", i), {63'd0, load_done}, 64'd0);
         tick();
         if (i < 2) load_data = words[i+1];
      end
      checkOutput("load_done_pulse", {63'd0, load_done}, 64'd1);
      checkOutput("load_ready_done", {63'd0, load_ready}, 64'd0);
      checkOutput("load_count_full", {55'd0, load_count}, 64'd3);
      load_mode  = 1'b0;
      load_valid = 1'b0;
      tick();
      checkOutput("load_done_once", {63'd0, load_done}, 64'd0);
      checkOutput("load_count_hold", {55'd0, load_count}, 64'd3);

      // Cpu read after load
      applyStimulus(1'b1, 64'd1, 64'd0);
      checkOutput("read_addr1", data, 64'h22);

      // Cpu write then read back; data holds during the write
      applyStimulus(1'b0, 64'd5, 64'hDEADBEEF);
      checkOutput("write_hold", data, 64'h22);
      applyStimulus(1'b1, 64'd5, 64'd0);
      checkOutput("read_addr5", data, 64'hDEADBEEF);

      // Out-of-range read
      applyStimulus(1'b1, 64'd256, 64'd0);
      checkOutput("oor_data", data, 64'd0);
      checkOutput("oor_fault", {63'd0, fault}, 64'd1);
      applyStimulus(1'b1, 64'd5, 64'd0);
      checkOutput("post_oor_data", data, 64'hDEADBEEF);
      checkOutput("post_oor_fault", {63'd0, fault}, 64'd1);
      applyStimulus(1'b1, 64'd0, 64'd0);
      checkOutput("read_addr0", data, 64'h11);

      // Reset clears the sticky fault
      reset = 1'b1;
      #1;
      checkOutput("reset_clears_fault", {63'd0, fault}, 64'd0);
      checkOutput("reset_clears_data", data, 64'd0);
      reset = 1'b0;
      tick();

      // Partial load: load_mode dropped after two accepts
      rw         = 1'b1;
      address    = 64'd0;
      load_mode  = 1'b1;
      load_len   = 9'd4;
      load_valid = 1'b1;
      load_data  = 64'hA0;
      tick();
      checkOutput("partial_count_entry", {55'd0, load_count}, 64'd0);
      tick();
      load_data = 64'hA1;
      tick();
      load_mode = 1'b0;
      #1;
      checkOutput("partial_ready_drop", {63'd0, load_ready}, 64'd0);
      tick();
      checkOutput("partial_done", {63'd0, load_done}, 64'd1);
      checkOutput("partial_count", {55'd0, load_count}, 64'd2);
      load_valid = 1'b0;
      tick();
      checkOutput("partial_done_end", {63'd0, load_done}, 64'd0);

      // Zero-length load ends without accepting anything
      load_mode  = 1'b1;
      load_len   = 9'd0;
      load_valid = 1'b1;
      load_data  = 64'hEE;
      tick();
      checkOutput("zero_len_ready", {63'd0, load_ready}, 64'd0);
      tick();
      checkOutput("zero_len_done", {63'd0, load_done}, 64'd1);
      checkOutput("zero_len_count", {55'd0, load_count}, 64'd0);
      load_mode  = 1'b0;
      load_valid = 1'b0;
      tick();

      // Second partial load interrupted by reset
      load_mode  = 1'b1;
      load_len   = 9'd4;
      load_valid = 1'b1;
      load_data  = 64'hB0;
      tick();
      tick();
      load_data = 64'hB1;
      tick();
      checkOutput("abort_count_before", {55'd0, load_count}, 64'd2);
      reset = 1'b1;
      #1;
      checkOutput("abort_ready", {63'd0, load_ready}, 64'd0);
      checkOutput("abort_done", {63'd0, load_done}, 64'd0);
      checkOutput("abort_count", {55'd0, load_count}, 64'd0);
      load_mode  = 1'b0;
      load_valid = 1'b0;
      reset      = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 64'(i), 64'd0);
         checkOutput($sformatf("abort_no_done_%0d", i), {63'd0, load_done}, 64'd0);
      end
      checkOutput("abort_keep_word2", data, 64'h33);
      applyStimulus(1'b1, 64'd0, 64'd0);
      checkOutput("abort_keep_word0", data, 64'hB0);
      applyStimulus(1'b1, 64'd1, 64'd0);
      checkOutput("abort_keep_word1", data, 64'hB1);
      applyStimulus(1'b1, 64'd5, 64'd0);
      checkOutput("abort_keep_word5", data, 64'hDEADBEEF);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
